// File: rtl/register.sv
// Single WIDTH-bit storage register with write enable, synchronous clear and a registered change pulse.
// Define REGISTER_SHADOW_EN to add reg_prev, which holds the value the register had before its last change.
module register #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] reg_input,
  input  logic             reg_write,
  input  logic             reg_clear,
  output logic [WIDTH-1:0] reg_output,
  output logic             reg_changed
`ifdef REGISTER_SHADOW_EN
  ,
  output logic [WIDTH-1:0] reg_prev
`endif
);

  logic [WIDTH-1:0] next_value;
  logic             value_changes;

  // Clear takes priority over write; with neither, the stored value is kept.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_value = reg_output;
    if (reg_clear) begin
      next_value = RESET_VALUE;
    end else if (reg_write) begin
      next_value = reg_input;
    end
    value_changes = (next_value != reg_output);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      reg_output  <= RESET_VALUE;
      reg_changed <= 1'b0;
    end else begin
      reg_output  <= next_value;
      reg_changed <= value_changes;
    end
  end

`ifdef REGISTER_SHADOW_EN
  // Captures the outgoing value only on edges that actually change the register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      reg_prev <= RESET_VALUE;
    end else if (value_changes) begin
      reg_prev <= reg_output;
    end
  end
`endif

endmodule

// File: tb/tb_register.sv
// Self-checking bench for register: directed scenarios plus randomized traffic against a behavioural model.
// Also checks reg_prev when compiled with REGISTER_SHADOW_EN.
module tb_register;

  localparam int unsigned      WIDTH = 16;
  localparam logic [WIDTH-1:0] RV    = '0;

  logic             CLK;
  logic             reset;
  logic [WIDTH-1:0] reg_input;
  logic             reg_write;
  logic             reg_clear;
  logic [WIDTH-1:0] reg_output;
  logic             reg_changed;
`ifdef REGISTER_SHADOW_EN
  logic [WIDTH-1:0] reg_prev;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [WIDTH-1:0] m_val;
  logic             m_chg;
  logic [WIDTH-1:0] m_prev;

  register #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .reg_input  (reg_input),
    .reg_write  (reg_write),
    .reg_clear  (reg_clear),
    .reg_output (reg_output),
    .reg_changed(reg_changed)
`ifdef REGISTER_SHADOW_EN
    ,
    .reg_prev   (reg_prev)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge, update the model from the inputs seen at that edge, return at the falling edge.
  task automatic cycle();
    logic [WIDTH-1:0] nxt;
    @(posedge CLK);
    if (!reset) begin
      m_val  = RV;
      m_chg  = 1'b0;
      m_prev = RV;
    end else begin
      nxt   = reg_clear ? RV : (reg_write ? reg_input : m_val);
      m_chg = (nxt != m_val);
      if (m_chg) m_prev = m_val;
      m_val = nxt;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    reset = 1'b0; reg_write = 1'b0; reg_clear = 1'b0; reg_input = 16'hA5A5;
    m_val = RV; m_chg = 1'b0; m_prev = RV;
    #1;
    total++;
    if (reg_output !== 16'h0000 || reg_changed !== 1'b0) begin
      bad++;
      $display("FAIL reset_immediate: out=%h chg=%b want out=0000 chg=0", reg_output, reg_changed);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++;
      if (reg_output !== 16'h0000 || reg_changed !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold%0d: out=%h chg=%b want out=0000 chg=0", i, reg_output, reg_changed);
      end
    end
    reset = 1'b1;
    cycle();
    total++;
    if (reg_output !== 16'h0000 || reg_changed !== 1'b0) begin
      bad++;
      $display("FAIL reset_after: out=%h chg=%b want out=0000 chg=0", reg_output, reg_changed);
    end
  endtask

  task automatic test_write();
    reg_input = 16'h8888; reg_write = 1'b1;
    cycle();
    total++;
    if (reg_output !== 16'h8888 || reg_changed !== 1'b1) begin
      bad++;
      $display("FAIL write_8888: out=%h chg=%b want out=8888 chg=1", reg_output, reg_changed);
    end
    reg_write = 1'b0; reg_input = 16'hFFFF;
    cycle();
    total++;
    if (reg_changed !== 1'b0) begin
      bad++;
      $display("FAIL write_pulse_len: chg=%b want 0", reg_changed);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      reg_input = (i % 2 == 0) ? 16'hFFFF : 16'($urandom);
      cycle();
      total++;
      if (reg_output !== 16'h8888 || reg_changed !== 1'b0) begin
        bad++;
        $display("FAIL hold%0d: out=%h chg=%b want out=8888 chg=0", i, reg_output, reg_changed);
      end
    end
  endtask

  task automatic test_rewrite_same();
    reg_input = 16'h8888; reg_write = 1'b1;
    cycle();
    total++;
    if (reg_output !== 16'h8888 || reg_changed !== 1'b0) begin
      bad++;
      $display("FAIL rewrite_same: out=%h chg=%b want out=8888 chg=0", reg_output, reg_changed);
    end
    reg_write = 1'b0;
  endtask

  task automatic test_clear_priority();
    reg_input = 16'h1234; reg_write = 1'b1; reg_clear = 1'b1;
    cycle();
    total++;
    if (reg_output !== 16'h0000 || reg_changed !== 1'b1) begin
      bad++;
      $display("FAIL clear_over_write: out=%h chg=%b want out=0000 chg=1", reg_output, reg_changed);
    end
    reg_write = 1'b0;
    cycle();
    total++;
    if (reg_output !== 16'h0000 || reg_changed !== 1'b0) begin
      bad++;
      $display("FAIL clear_at_reset_value: out=%h chg=%b want out=0000 chg=0", reg_output, reg_changed);
    end
    reg_clear = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vals [4];
    vals[0] = 16'h0001; vals[1] = 16'hBEEF; vals[2] = 16'h7F00; vals[3] = 16'hC0DE;
    reg_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      reg_input = vals[i];
      cycle();
      total++;
      if (reg_output !== vals[i] || reg_changed !== 1'b1) begin
        bad++;
        $display("FAIL b2b%0d: out=%h chg=%b want out=%h chg=1", i, reg_output, reg_changed, vals[i]);
      end
    end
    reg_write = 1'b0; reg_input = 16'h0000;
    cycle();
    total++;
    if (reg_output !== 16'hC0DE || reg_changed !== 1'b0) begin
      bad++;
      $display("FAIL b2b_last_held: out=%h chg=%b want out=c0de chg=0", reg_output, reg_changed);
    end
  endtask

  task automatic test_async_reset();
    reg_input = 16'h8888; reg_write = 1'b1;
    cycle();
    reg_write = 1'b0;
    cycle();
    // Assert reset between edges, with a write of 0x5555 pending
    #2;
    reset = 1'b0; reg_input = 16'h5555; reg_write = 1'b1;
    #1;
    total++;
    if (reg_output !== 16'h0000 || reg_changed !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_now: out=%h chg=%b want out=0000 chg=0", reg_output, reg_changed);
    end
    cycle();
    total++;
    if (reg_output !== 16'h0000 || reg_changed !== 1'b0) begin
      bad++;
      $display("FAIL write_under_reset: out=%h chg=%b want out=0000 chg=0", reg_output, reg_changed);
    end
`ifdef REGISTER_SHADOW_EN
    total++;
    if (reg_prev !== RV) begin
      bad++;
      $display("FAIL prev_reset: prev=%h want %h", reg_prev, RV);
    end
`endif
    reset = 1'b1;
    cycle();
    total++;
    if (reg_output !== 16'h5555 || reg_changed !== 1'b1) begin
      bad++;
      $display("FAIL first_edge_after_reset: out=%h chg=%b want out=5555 chg=1", reg_output, reg_changed);
    end
    reg_write = 1'b0;
  endtask

`ifdef REGISTER_SHADOW_EN
  task automatic test_shadow();
    reg_write = 1'b1;
    reg_input = 16'h8888;
    cycle();
    reg_input = 16'h1111;
    cycle();
    total++;
    if (reg_output !== 16'h1111 || reg_prev !== 16'h8888) begin
      bad++;
      $display("FAIL shadow_update: out=%h prev=%h want out=1111 prev=8888", reg_output, reg_prev);
    end
    cycle();
    total++;
    if (reg_prev !== 16'h8888 || reg_changed !== 1'b0) begin
      bad++;
      $display("FAIL shadow_rewrite: prev=%h chg=%b want prev=8888 chg=0", reg_prev, reg_changed);
    end
    reg_write = 1'b0;
  endtask
`endif

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      reg_clear = ($urandom_range(0, 9) == 0);
      reg_write = $urandom_range(0, 1) == 1;
      reg_input = ($urandom_range(0, 3) == 0) ? m_val : 16'($urandom);
      cycle();
      total++;
      if (reg_output !== m_val || reg_changed !== m_chg) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL random%0d: out=%h chg=%b want out=%h chg=%b",
                   i, reg_output, reg_changed, m_val, m_chg);
      end
`ifdef REGISTER_SHADOW_EN
      total++;
      if (reg_prev !== m_prev) begin
        bad++;
        if (errs++ < 10) $display("FAIL random_prev%0d: prev=%h want %h", i, reg_prev, m_prev);
      end
`endif
    end
    reg_clear = 1'b0; reg_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_hold();
    test_rewrite_same();
    test_clear_priority();
    test_back_to_back();
    test_async_reset();
`ifdef REGISTER_SHADOW_EN
    test_shadow();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
